oclib_dummy_logic_ctrl: RTL and testbench
=========================================

OCLIB_DUMMY_LOGIC_CTRL -- requirements
Module: oclib_dummy_logic_ctrl

Interface
REQ-001: Parameter DatapathWidth, default 32, sets the width of the driven and observed datapath.
REQ-002: Parameter PipeLatency, default 9, is the clock-to-clock latency from dpIn to dpOut of the controlled datapath; legal range is 1 or more.
REQ-003: Parameter CountWidth, default 32, is the width of runCycles.
REQ-004: Parameter Seed, default 1, is the LFSR start value; a Seed of 0 SHALL be loaded as 1.
REQ-005: Parameter Taps, default 32'h80200003, is the shared LFSR/MISR feedback mask, sized to DatapathWidth.
REQ-006: clock  in  1  sole clock; all state SHALL be on its rising edge.
REQ-007: reset  in  1  asynchronous, active-high reset.
REQ-008: start  in  1  run request, sampled in IDLE only.
REQ-009: abort  in  1  terminates an active run.
REQ-010: runCycles  in  CountWidth  number of stimulus words per run, sampled with start.
REQ-011: dpIn  out  DatapathWidth  stimulus to the datapath.
REQ-012: dpOut  in  DatapathWidth  datapath result.
REQ-013: busy  out  1  high in every state except IDLE.
REQ-014: done  out  1  single-cycle completion pulse.
REQ-015: signature  out  DatapathWidth  MISR result, held until the next accepted start.

Function
REQ-016: The FSM SHALL use the states IDLE, RUN, DRAIN and DONE; DONE SHALL always return to IDLE after one cycle.
REQ-017: Cycle numbering: the cycle in which start is sampled high in IDLE is cycle 0.
REQ-018: On accepting start, the block SHALL clear signature to 0, reload the LFSR with Seed and latch runCycles as N.
REQ-019: For N>0, RUN SHALL occupy cycles 1..N, DRAIN SHALL occupy cycles N+1..N+PipeLatency, and DONE (done=1) SHALL occur in cycle N+PipeLatency+1.
REQ-020: For N=0, the block SHALL go directly to DONE in cycle 1, with signature equal to 0.
REQ-021: In RUN cycle k, dpIn SHALL carry the k-th LFSR value, where the first value is Seed.
REQ-022: LFSR next-state SHALL be {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? Taps : 0).
REQ-023: Outside RUN, dpIn SHALL be 0.
REQ-024: A valid bit SHALL be delayed PipeLatency cycles alongside dpIn.
REQ-025: dpOut SHALL be folded into the MISR exactly in cycles PipeLatency+1..N+PipeLatency, i.e. N samples.
REQ-026: MISR update SHALL be sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? Taps : 0) ^ dpOut.
REQ-027: A start asserted while busy SHALL be ignored, with no queuing.
REQ-028: abort in RUN or DRAIN SHALL force IDLE on the next cycle, drive dpIn to 0, clear the valid pipe, suppress done, and leave signature partial.
REQ-029: abort in IDLE or DONE SHALL have no effect.
REQ-030: If start and abort are both high in IDLE, start SHALL win.
REQ-031: runCycles of all-ones SHALL be honoured without counter wrap; the counter is CountWidth bits and counts down.

Reset
REQ-032: While reset is high: state IDLE, busy=0, done=0, dpIn=0, signature=0, valid pipe cleared, LFSR=Seed.
REQ-033: Reset asserted mid-run SHALL abandon the run immediately with no done pulse.
REQ-034: The first start SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-035: Macro OC_DUMMY_LOGIC_CTRL_CHECK_EN, when defined, SHALL add input expectSig [DatapathWidth], output pass [1] and output fail [1].
REQ-036: With the macro defined, in the DONE cycle pass SHALL equal (final signature == expectSig) and fail SHALL be its inverse.
REQ-037: With the macro defined, pass and fail SHALL hold until the next accepted start, which clears both; both SHALL reset to 0.
REQ-038: Without the macro, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039: PipeLatency=3, loopback model dpOut=dpIn delayed 3, N=1, Seed=1 -> dpIn=1 in cycle 1, done in cycle 5, signature=32'h00000001.
REQ-040: N=0 -> busy high in cycle 1 only, done in cycle 1, signature=0, dpIn stays 0.
REQ-041: N=4, start re-pulsed in cycle 2 -> second start ignored, exactly one done in cycle 8 (PipeLatency=3).
REQ-042: N=10, abort in cycle 5 -> IDLE and busy=0 in cycle 6, no done, dpIn=0 from cycle 6.
REQ-043: N=10, reset asserted in cycle 7 -> all outputs 0 immediately; a new start after reset gives the same signature as an uninterrupted N=10 run.
REQ-044: With CHECK_EN defined, N=1 run from REQ-039 with expectSig=1 -> pass=1, fail=0; with expectSig=2 -> pass=0, fail=1.

Source files
------------

// File: rtl/oclib_dummy_logic_ctrl.sv
// LFSR-driven stimulus generator and MISR result compactor for a pipelined datapath under test.
// Optional pass/fail comparison against an expected signature: define OC_DUMMY_LOGIC_CTRL_CHECK_EN.
module oclib_dummy_logic_ctrl #(
   parameter int DatapathWidth = 32,
   parameter int PipeLatency   = 9,
   parameter int CountWidth    = 32,
   parameter logic [DatapathWidth-1:0] Seed = DatapathWidth'(1),
   parameter logic [DatapathWidth-1:0] Taps = DatapathWidth'(32'h80200003)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CountWidth-1:0]    runCycles,
   output logic [DatapathWidth-1:0] dpIn,
   input  logic [DatapathWidth-1:0] dpOut,
   output logic                     busy,
   output logic                     done,
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
   input  logic [DatapathWidth-1:0] expectSig,
   output logic                     pass,
   output logic                     fail,
`endif
   output logic [DatapathWidth-1:0] signature
);

   localparam int W  = DatapathWidth;
   localparam int DW = $clog2(PipeLatency + 1);
   localparam logic [DW-1:0] DrainLoad = DW'(PipeLatency);
   localparam logic [W-1:0]  SeedEff   = (Seed == '0) ? W'(1) : Seed;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [W-1:0]          lfsr;
   logic [CountWidth-1:0] cnt;
   logic [DW-1:0]         dcnt;
   logic [PipeLatency:0]  vld_pipe;
   logic [W-1:0]          sig_nxt;

   function automatic logic [W-1:0] step(input logic [W-1:0] x);
      return {x[W-2:0], 1'b0} ^ (x[W-1] ? Taps : '0);
   endfunction

   // vld_pipe[PipeLatency] marks the cycle in which dpOut belongs to a stimulus word
   always_comb begin
      sig_nxt = signature;
      if (vld_pipe[PipeLatency]) sig_nxt = step(signature) ^ dpOut;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dpIn      <= '0;
         signature <= '0;
         vld_pipe  <= '0;
         lfsr      <= SeedEff;
         cnt       <= '0;
         dcnt      <= '0;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
         pass      <= 1'b0;
         fail      <= 1'b0;
`endif
      end else begin
         done                    <= 1'b0;
         signature               <= sig_nxt;
         vld_pipe[PipeLatency:1] <= vld_pipe[PipeLatency-1:0];
         vld_pipe[0]             <= 1'b0;
         case (state)
            IDLE: begin
               dpIn <= '0;
               if (start) begin
                  signature <= '0;
                  cnt       <= runCycles;
                  busy      <= 1'b1;
                  lfsr      <= SeedEff;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
                  pass      <= 1'b0;
                  fail      <= 1'b0;
`endif
                  if (runCycles == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
                     pass  <= (expectSig == '0);
                     fail  <= (expectSig != '0);
`endif
                  end else begin
                     state       <= RUN;
                     dpIn        <= SeedEff;
                     lfsr        <= step(SeedEff);
                     vld_pipe[0] <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  dpIn     <= '0;
                  vld_pipe <= '0;
               end else if (cnt == CountWidth'(1)) begin
                  state <= DRAIN;
                  dpIn  <= '0;
                  dcnt  <= DrainLoad;
               end else begin
                  cnt         <= cnt - 1'b1;
                  dpIn        <= lfsr;
                  lfsr        <= step(lfsr);
                  vld_pipe[0] <= 1'b1;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  vld_pipe <= '0;
               end else if (dcnt == DW'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
                  // compare against the value that includes this edge's final fold
                  pass  <= (sig_nxt == expectSig);
                  fail  <= (sig_nxt != expectSig);
`endif
               end else begin
                  dcnt <= dcnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oclib_dummy_logic_ctrl.sv
// Table-driven bench for oclib_dummy_logic_ctrl with a 3-cycle loopback datapath model.
module tb_oclib_dummy_logic_ctrl;

   localparam int L = 3;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic        clock, reset, start, abort;
   logic [31:0] runCycles, dpIn, dpOut, signature;
   logic        busy, done;
   logic [31:0] mask;
   logic [31:0] lb0, lb1, lb2;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
   logic [31:0] expectSig;
   logic        pass, fail;
`endif

   int checks = 0;
   int failures = 0;

   oclib_dummy_logic_ctrl #(.DatapathWidth(32), .PipeLatency(L), .CountWidth(32)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .runCycles(runCycles),
      .dpIn(dpIn), .dpOut(dpOut), .busy(busy), .done(done),
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
      .expectSig(expectSig), .pass(pass), .fail(fail),
`endif
      .signature(signature));

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // datapath model: dpOut is dpIn delayed L cycles, optionally xored with a mask
   always @(posedge clock) begin
      lb0 <= dpIn;
      lb1 <= lb0;
      lb2 <= lb1;
   end
   assign dpOut = lb2 ^ mask;

   function automatic logic [31:0] nxt(input logic [31:0] x);
      return {x[30:0], 1'b0} ^ (x[31] ? TAPS : 32'h0);
   endfunction

   function automatic logic [31:0] ref_lfsr(input int k);
      logic [31:0] l = 32'h1;
      for (int i = 1; i < k; i++) l = nxt(l);
      return l;
   endfunction

   function automatic logic [31:0] ref_sig(input int n, input logic [31:0] m);
      logic [31:0] l = 32'h1;
      logic [31:0] s = 32'h0;
      for (int i = 1; i <= n; i++) begin
         s = nxt(s) ^ (l ^ m);
         l = nxt(l);
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // cycle 0 is the cycle in which start is presented; outputs are sampled at each negedge
   task automatic do_run(input int n, input int abort_at, input int restart_at, input bit no_wait,
                         output int done_cyc, output int done_cnt, output int last_busy,
                         output int dpin_bad);
      logic [31:0] e;
      done_cyc = -1; done_cnt = 0; last_busy = 0; dpin_bad = 0;
      if (!no_wait) @(negedge clock);
      start = 1; runCycles = n; abort = (abort_at == 0);
      for (int c = 1; c <= n + 8; c++) begin
         @(negedge clock);
         if (done) begin done_cnt++; done_cyc = c; end
         if (busy) last_busy = c;
         e = (c <= n && !(abort_at >= 1 && c > abort_at)) ? ref_lfsr(c) : 32'h0;
         if (dpIn !== e) dpin_bad++;
         start = (c == restart_at);
         abort = (c == abort_at);
      end
      start = 0; abort = 0;
   endtask

   typedef struct {
      int          n;
      logic [31:0] m;
      int          abort_at;
      int          restart_at;
      int          exp_done_cyc;
      int          exp_done_cnt;
      int          exp_last_busy;
      bit          chk_sig;
      logic [31:0] exp_sig;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int dc, dn, lb, bad;
      logic [31:0] ps;
      vecs[0] = '{1,  32'h0,        -1, -1, 5,  1, 5,  1, 32'h00000001};
      vecs[1] = '{0,  32'h0,        -1, -1, 1,  1, 1,  1, 32'h00000000};
      vecs[2] = '{4,  32'h12345678, -1,  2, 8,  1, 8,  1, ref_sig(4, 32'h12345678)};
      vecs[3] = '{10, 32'h0,         5, -1, -1, 0, 5,  0, 32'h0};
      vecs[4] = '{10, 32'h0,        -1, -1, 14, 1, 14, 1, 32'h00000000};
      vecs[5] = '{40, 32'hdeadbeef, -1, -1, 44, 1, 44, 1, ref_sig(40, 32'hdeadbeef)};
      vecs[6] = '{3,  32'h00ff00ff,  0, -1, 7,  1, 7,  1, ref_sig(3, 32'h00ff00ff)};
      vecs[7] = '{10, 32'h0f0f0f0f, 12, -1, -1, 0, 12, 0, 32'h0};
      vecs[8] = '{7,  32'ha5a50000, -1, -1, 11, 1, 11, 1, ref_sig(7, 32'ha5a50000)};

      reset = 1; start = 0; abort = 0; runCycles = 0; mask = 0;
`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
      expectSig = 0;
`endif
      repeat (3) @(negedge clock);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_dpin", dpIn, 32'h0);
      chk("rst_sig", signature, 32'h0);
      reset = 0;

      for (int i = 0; i < 9; i++) begin
         mask = vecs[i].m;
         do_run(vecs[i].n, vecs[i].abort_at, vecs[i].restart_at, 0, dc, dn, lb, bad);
         chk($sformatf("v%0d_done_cnt", i), dn, vecs[i].exp_done_cnt);
         if (vecs[i].exp_done_cnt > 0) chk($sformatf("v%0d_done_cyc", i), dc, vecs[i].exp_done_cyc);
         chk($sformatf("v%0d_last_busy", i), lb, vecs[i].exp_last_busy);
         chk($sformatf("v%0d_dpin", i), bad, 0);
         if (vecs[i].chk_sig) chk($sformatf("v%0d_sig", i), signature, vecs[i].exp_sig);
      end

      // abort alone in IDLE does nothing
      @(negedge clock); abort = 1;
      @(negedge clock); abort = 0;
      chk("idle_abort_busy", {31'h0, busy}, 32'h0);

      // reset mid-run, then restart in the first cycle after release
      mask = 32'h5a5a5a5a;
      @(negedge clock); start = 1; runCycles = 10;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock); start = 0;
      end
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      ps = signature;
      reset = 1; #1;
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_dpin", dpIn, 32'h0);
      chk("mid_rst_sig", signature, 32'h0);
      chk("mid_rst_done", {31'h0, done}, 32'h0);
      repeat (4) @(negedge clock);
      chk("rst_no_done", {31'h0, done}, 32'h0);
      reset = 0;
      do_run(10, -1, -1, 1, dc, dn, lb, bad);
      chk("post_rst_done_cyc", dc, 14);
      chk("post_rst_dpin", bad, 0);
      chk("post_rst_sig", signature, ref_sig(10, 32'h5a5a5a5a));
      if (ps === 32'h0) chk("pre_rst_sig_nonzero", 32'h1, 32'h0);

`ifdef OC_DUMMY_LOGIC_CTRL_CHECK_EN
      mask = 0; expectSig = 32'h1;
      do_run(1, -1, -1, 0, dc, dn, lb, bad);
      chk("chk_pass1", {31'h0, pass}, 32'h1);
      chk("chk_fail1", {31'h0, fail}, 32'h0);
      expectSig = 32'h2;
      do_run(1, -1, -1, 0, dc, dn, lb, bad);
      chk("chk_pass2", {31'h0, pass}, 32'h0);
      chk("chk_fail2", {31'h0, fail}, 32'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
